// File: rtl/oled_frame_streamer.sv
// Raster-scans a WIDTH x HEIGHT RGB565 panel, fetching each pixel from the
// combinational screen generator and shifting it out MSB-first over mode-0 SPI.
module oled_frame_streamer #(
    parameter int WIDTH   = 96,
    parameter int HEIGHT  = 64,
    parameter int CLK_DIV = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        frame_start,
    input  logic [15:0] oled_data,
    output logic [6:0]  x,
    output logic [5:0]  y,
    output logic        busy,
    output logic        frame_done,
    output logic        spi_sclk,
    output logic        spi_mosi,
    output logic        spi_cs_n,
    output logic        spi_dc
);

    localparam int            DW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [6:0]    X_LAST   = 7'(WIDTH - 1);
    localparam logic [5:0]    Y_LAST   = 6'(HEIGHT - 1);

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

    state_t        state_q, state_d;
    logic [6:0]    x_q, x_d;
    logic [5:0]    y_q, y_d;
    logic [15:0]   shift_q, shift_d;
    logic [3:0]    bit_q, bit_d;
    logic [DW-1:0] div_q, div_d;
    logic          hi_q, hi_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            x_q     <= '0;
            y_q     <= '0;
            shift_q <= '0;
            bit_q   <= '0;
            div_q   <= '0;
            hi_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            shift_q <= shift_d;
            bit_q   <= bit_d;
            div_q   <= div_d;
            hi_q    <= hi_d;
        end
    end

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        shift_d = shift_q;
        bit_d   = bit_q;
        div_d   = div_q;
        hi_d    = hi_q;
        case (state_q)
            IDLE: begin
                if (frame_start) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                shift_d = oled_data;
                bit_d   = '0;
                div_d   = '0;
                hi_d    = 1'b0;
                state_d = SHIFT;
            end
            SHIFT: begin
                if (div_q == DIV_LAST) begin
                    div_d = '0;
                    if (!hi_q) begin
                        hi_d = 1'b1;
                    end else begin
                        // End of a high half: shift, and after bit 0 advance the raster.
                        hi_d    = 1'b0;
                        shift_d = {shift_q[14:0], 1'b0};
                        if (bit_q == 4'd15) begin
                            bit_d = '0;
                            if (x_q != X_LAST) begin
                                x_d     = x_q + 7'd1;
                                state_d = LOAD;
                            end else if (y_q != Y_LAST) begin
                                x_d     = '0;
                                y_d     = y_q + 6'd1;
                                state_d = LOAD;
                            end else begin
                                state_d = DONE;
                            end
                        end else begin
                            bit_d = bit_q + 4'd1;
                        end
                    end
                end else begin
                    div_d = div_q + DW'(1);
                end
            end
            DONE: begin
                x_d     = '0;
                y_d     = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign x          = x_q;
    assign y          = y_q;
    assign busy       = (state_q != IDLE);
    assign frame_done = (state_q == DONE);
    assign spi_cs_n   = !((state_q == LOAD) || (state_q == SHIFT));
    assign spi_dc     = !spi_cs_n;
    assign spi_sclk   = (state_q == SHIFT) && hi_q;
    assign spi_mosi   = shift_q[15];

endmodule

// File: tb/tb_oled_frame_streamer.sv
// Scoreboarded bench: expected words queued per frame, a negedge monitor
// deserialises the SPI stream and checks link/handshake rules every cycle.
module tb_oled_frame_streamer;

    localparam int W  = 5;
    localparam int H  = 3;
    localparam int CD = 3;
    localparam int P  = 1 + 32 * CD;
    localparam int N  = W * H;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        frame_start = 1'b0;
    logic [15:0] oled_data;
    logic [6:0]  x;
    logic [5:0]  y;
    logic        busy, frame_done, spi_sclk, spi_mosi, spi_cs_n, spi_dc;

    logic [15:0] pix [H][W];
    logic [15:0] exp_q [$];
    int          total = 0;
    int          bad = 0;
    int          ndone = 0;
    int          nrise = 0;
    int          nbits = 0;
    logic [15:0] sh = '0;
    logic        sclk_prev = 1'b0;
    logic        mosi_prev = 1'b0;

    oled_frame_streamer #(.WIDTH(W), .HEIGHT(H), .CLK_DIV(CD)) dut (
        .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .oled_data(oled_data),
        .x(x), .y(y), .busy(busy), .frame_done(frame_done), .spi_sclk(spi_sclk),
        .spi_mosi(spi_mosi), .spi_cs_n(spi_cs_n), .spi_dc(spi_dc)
    );

    always #5 clk = ~clk;

    // Behavioural screen generator: a random picture looked up by coordinate.
    assign oled_data = (int'(x) < W && int'(y) < H) ? pix[int'(y)][int'(x)] : 16'hDEAD;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: samples mid-cycle, reassembles words on sclk rises.
    always @(negedge clk) begin
        if (!rst_n) begin
            nbits = 0;
        end else begin
            if (frame_done) ndone++;
            if (spi_mosi !== mosi_prev && spi_sclk) begin
                total++; bad++;
                $display("FAIL mosi_stable: mosi changed to %0b while sclk=1", spi_mosi);
            end
            if (busy) chk("cs_n_frame", int'(spi_cs_n), int'(frame_done));
            chk("dc_vs_cs", int'(spi_dc), int'(!spi_cs_n));
            if (spi_sclk && !sclk_prev) begin
                nrise++;
                sh = {sh[14:0], spi_mosi};
                nbits++;
                if (nbits == 16) begin
                    nbits = 0;
                    if (exp_q.size() == 0) begin
                        total++; bad++;
                        $display("FAIL word_extra: got %0h expected none", sh);
                    end else begin
                        chk("word", int'(sh), int'(exp_q.pop_front()));
                    end
                end
            end
        end
        sclk_prev = spi_sclk;
        mosi_prev = spi_mosi;
    end

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_x"}, int'(x), 0);
        chk({tag, "_y"}, int'(y), 0);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_done"}, int'(frame_done), 0);
        chk({tag, "_sclk"}, int'(spi_sclk), 0);
        chk({tag, "_mosi"}, int'(spi_mosi), 0);
        chk({tag, "_cs_n"}, int'(spi_cs_n), 1);
        chk({tag, "_dc"}, int'(spi_dc), 0);
    endtask

    task automatic new_picture();
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++) begin
                pix[r][c] = 16'($urandom);
                exp_q.push_back(pix[r][c]);
            end
    endtask

    // Streams one frame; with poke set, frame_start is also pulsed in SHIFT and DONE.
    task automatic run_frame(input bit poke);
        int n;
        int d0;
        int r0;
        new_picture();
        d0 = ndone;
        r0 = nrise;
        @(negedge clk) frame_start = 1'b1;
        @(posedge clk); #1 frame_start = 1'b0;
        chk("busy_after_accept", int'(busy), 1);
        n = 0;
        while (!frame_done && n < N * P + 10) begin
            if (n % P == 0 && n < N * P) begin
                chk("raster_x", int'(x), (n / P) % W);
                chk("raster_y", int'(y), (n / P) / W);
            end
            frame_start = (poke && n == P + 5);
            @(posedge clk); #1;
            n++;
        end
        frame_start = 1'b0;
        chk("done_latency", n, N * P);
        chk("last_x", int'(x), W - 1);
        chk("last_y", int'(y), H - 1);
        if (poke) frame_start = 1'b1;
        @(posedge clk); #1 frame_start = 1'b0;
        chk("idle_busy", int'(busy), 0);
        chk("idle_x", int'(x), 0);
        chk("idle_y", int'(y), 0);
        chk("idle_cs_n", int'(spi_cs_n), 1);
        repeat (3) @(posedge clk);
        #1;
        chk("still_idle", int'(busy), 0);
        chk("done_count", ndone - d0, 1);
        chk("sclk_rises", nrise - r0, 16 * N);
        chk("queue_drained", exp_q.size(), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        int d0;
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++) pix[r][c] = '0;

        repeat (8) begin
            @(negedge clk) frame_start = 1'($urandom);
            #1 chk_reset_outputs("in_reset");
        end
        frame_start = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        repeat (40) @(posedge clk);
        #1 chk_reset_outputs("idle_after_reset");

        run_frame(1'b0);
        run_frame(1'b1);

        // Abandon a frame mid-bit at pixel (2,1).
        new_picture();
        d0 = ndone;
        @(negedge clk) frame_start = 1'b1;
        @(posedge clk); #1 frame_start = 1'b0;
        n = 0;
        while (n < 7 * P + 1 + 5 * CD + 1) begin
            @(posedge clk); #1;
            n++;
        end
        chk("pre_reset_x", int'(x), 2);
        chk("pre_reset_y", int'(y), 1);
        #2 rst_n = 1'b0;
        #1 chk_reset_outputs("async_reset");
        exp_q.delete();
        repeat (4) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1 chk_reset_outputs("post_abort");
        chk("no_done_on_abort", ndone - d0, 0);

        run_frame(1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
